// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: datapath widths, ALU control codes
// and the operand-forwarding select encoding.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int ALU_CW = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // r0 is hard-wired, so it never takes a bypass; the newer EX/MEM result beats MEM/WB.
  function automatic fwd_sel_e fwd_select(input logic idx_zero,
                                          input logic exm_hit,
                                          input logic wb_hit);
    if (idx_zero)     return FWD_REG;
    else if (exm_hit) return FWD_EXM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass mux for one source register: picks the register-file value
// or a newer in-flight result from EX/MEM or MEM/WB.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    sel = fwd_select(idx == '0,
                     exm_reg_write && (exm_rd == idx),
                     wb_reg_write && (wb_rd == idx));
    fwd_data = reg_data;
    case (sel)
      FWD_EXM: fwd_data = exm_result;
      FWD_WB:  fwd_data = wb_data;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and the EX-stage
// operand front end (forwarding and ALU source select).
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW,
  parameter int ALU_CW = mips_pkg::ALU_CW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [ALU_CW-1:0] id_alu_ctrl,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [DATA_W-1:0] alu_r1,
  output logic [DATA_W-1:0] alu_r2,
  output logic [ALU_CW-1:0] alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              alu_src_q, alu_src_d;
  logic [ALU_CW-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              reg_write_q, reg_write_d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // rt only matters as a source when it feeds the ALU or is the store data.
  always_comb begin
    stall = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
            ((rd_q == id_rs) ||
             ((rd_q == id_rt) && (!id_alu_src || id_mem_write)));
  end

  always_comb begin
    valid_d     = 1'b0;
    rs_d        = '0;
    rt_d        = '0;
    rd_d        = '0;
    rs_data_d   = '0;
    rt_data_d   = '0;
    imm_d       = '0;
    alu_src_d   = 1'b0;
    alu_ctrl_d  = ALU_CW'(ALU_ADD);
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    if (!flush && !stall) begin
      valid_d     = id_valid;
      rs_d        = id_rs;
      rt_d        = id_rt;
      rd_d        = id_rd;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      alu_ctrl_d  = id_alu_ctrl;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
      reg_write_d = id_reg_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= ALU_CW'(ALU_ADD);
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .idx           (rs_q),
    .reg_data      (rs_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fwd_data      (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .idx           (rt_q),
    .reg_data      (rt_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fwd_data      (rt_fwd)
  );

  always_comb begin
    alu_r1        = rs_fwd;
    alu_r2        = alu_src_q ? imm_q : rt_fwd;
    ex_store_data = rt_fwd;
    alu_control   = alu_ctrl_q;
    ex_rd         = rd_q;
    ex_valid      = valid_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_reg_write  = reg_write_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding priority, load-use
// stall, flush handling and asynchronous reset.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [2:0]  id_alu_ctrl;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] alu_r1, alu_r2, ex_store_data;
  logic [2:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_alu_src    (id_alu_src),
    .id_alu_ctrl   (id_alu_ctrl),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_reg_write  (id_reg_write),
    .flush         (flush),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .stall         (stall),
    .alu_r1        (alu_r1),
    .alu_r2        (alu_r2),
    .alu_control   (alu_control),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive one decoded ID instruction.
  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic src, input logic [2:0] ctrl,
                        input logic mr, input logic mw, input logic rw);
    id_valid = v;      id_rs = rs;        id_rt = rt;       id_rd = rd;
    id_rs_data = rsd;  id_rt_data = rtd;  id_imm = imm;     id_alu_src = src;
    id_alu_ctrl = ctrl; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task automatic taps(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                      input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
    exm_reg_write = ew; exm_rd = erd; exm_result = eres;
    wb_reg_write = ww;  wb_rd = wrd;  wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0);
    taps(0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_control), 32'(ALU_ADD));
    chk("rst_alu_r1", alu_r1, 32'd0);
    chk("rst_alu_r2", alu_r2, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Plain capture, then EX/MEM forward on rs=5
    id_set(1, 5, 7, 3, 32'h99, 32'h77, 0, 0, ALU_SUB, 0, 0, 1);
    tick();
    chk("cap_alu_r1", alu_r1, 32'h99);
    chk("cap_alu_r2", alu_r2, 32'h77);
    chk("cap_ctrl", 32'(alu_control), 32'(ALU_SUB));
    chk("cap_ex_rd", 32'(ex_rd), 32'd3);
    chk("cap_reg_write", 32'(ex_reg_write), 32'd1);
    taps(1, 5, 32'h11, 0, 0, 0);
    #1;
    chk("exm_fwd_rs5", alu_r1, 32'h11);
    id_set(1, 0, 7, 3, 32'h99, 32'h77, 0, 0, ALU_ADD, 0, 0, 1);
    taps(1, 0, 32'h11, 0, 0, 0);
    tick();
    chk("no_fwd_rs0", alu_r1, 32'h99);

    // EX/MEM beats MEM/WB, then immediate selection on r2
    id_set(1, 1, 7, 4, 32'h1, 32'h55, 0, 0, ALU_OR, 0, 0, 1);
    taps(1, 7, 32'hA, 1, 7, 32'hB);
    tick();
    chk("prio_alu_r2", alu_r2, 32'hA);
    chk("prio_store", ex_store_data, 32'hA);
    exm_reg_write = 1'b0;
    #1;
    chk("wb_fwd_r2", alu_r2, 32'hB);
    exm_reg_write = 1'b1;
    id_set(1, 1, 7, 4, 32'h1, 32'h55, 32'h4, 1, ALU_ADD, 0, 0, 1);
    tick();
    chk("imm_alu_r2", alu_r2, 32'h4);
    chk("imm_store", ex_store_data, 32'hA);

    // Load-use: lw $8 followed by add $9,$8,$1
    taps(0, 0, 0, 0, 0, 0);
    id_set(1, 2, 8, 8, 32'h100, 32'h0, 32'h8, 1, ALU_ADD, 1, 0, 1);
    tick();
    chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
    id_set(1, 3, 8, 10, 0, 0, 32'h4, 1, ALU_ADD, 0, 0, 1);
    #1;
    chk("addi_rt_nostall", 32'(stall), 32'd0);
    id_set(1, 3, 8, 0, 0, 0, 32'h4, 1, ALU_ADD, 0, 1, 0);
    #1;
    chk("sw_rt_stall", 32'(stall), 32'd1);
    id_set(1, 8, 1, 9, 32'hDEAD, 32'h5, 0, 0, ALU_ADD, 0, 0, 1);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("lu_stall_drop", 32'(stall), 32'd0);
    taps(0, 0, 0, 1, 8, 32'h1234);
    tick();
    taps(0, 0, 0, 1, 8, 32'h1234);
    #1;
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_ex_rd", 32'(ex_rd), 32'd9);
    chk("lu_add_wb_fwd", alu_r1, 32'h1234);
    chk("lu_add_r2", alu_r2, 32'h5);

    // Flush and stall together, then flush alone
    taps(0, 0, 0, 0, 0, 0);
    id_set(1, 2, 8, 8, 32'h100, 0, 32'h8, 1, ALU_ADD, 1, 0, 1);
    tick();
    id_set(1, 8, 1, 9, 0, 0, 0, 0, ALU_ADD, 0, 0, 1);
    flush = 1'b1;
    #1;
    chk("fs_stall", 32'(stall), 32'd1);
    tick();
    chk("fs_bubble", 32'(ex_valid), 32'd0);
    id_set(1, 4, 5, 6, 32'h3, 32'h4, 0, 0, ALU_XOR, 0, 0, 1);
    tick();
    chk("fl_valid", 32'(ex_valid), 32'd0);
    chk("fl_reg_write", 32'(ex_reg_write), 32'd0);
    chk("fl_ex_rd", 32'(ex_rd), 32'd0);
    flush = 1'b0;

    // Asynchronous reset while a load-use stall is active
    id_set(1, 2, 8, 8, 32'h100, 0, 32'h8, 1, ALU_ADD, 1, 0, 1);
    tick();
    id_set(1, 8, 1, 9, 0, 0, 0, 0, ALU_ADD, 0, 0, 1);
    #1;
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_mem_read", 32'(ex_mem_read), 32'd0);
    chk("arst_reg_write", 32'(ex_reg_write), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_alu_r2", alu_r2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
